// File: rtl/ula_pkg.sv
// ula_pkg: shared opcodes, FSM states and sizing helper for the sequential ULA
package ula_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;
    localparam logic [2:0] OP_MOD = 3'b111;
    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;
    typedef enum logic [1:0] {IDLE, CALC, FIM} state_t;
    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction
endpackage

// File: rtl/ula_iter_muldiv.sv
// ula_iter_muldiv: iterative shift-add multiplier / restoring divider, one bit per clock
module ula_iter_muldiv
    import ula_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           mode,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] prod,
    output logic [W-1:0]   quo,
    output logic [W-1:0]   rem,
    output logic           step_last
);
    localparam int CW = cnt_w(W);
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0] opr_q, opr_d;
    logic mode_q, mode_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W:0] trial, mul_sum;
    // acc holds {partial product, multiplier} for MUL and {remainder, dividend} for DIV
    always_comb begin
        trial = acc_q[2*W-1:W-1];
        mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opr_q} : '0);
        acc_d = acc_q;
        opr_d = opr_q;
        mode_d = mode_q;
        cnt_d = cnt_q;
        if (load) begin
            acc_d = {{W{1'b0}}, (mode == MODE_DIV) ? a : b};
            opr_d = (mode == MODE_DIV) ? b : a;
            mode_d = mode;
            cnt_d = '0;
        end else if (cnt_q != CW'(W)) begin
            cnt_d = cnt_q + CW'(1);
            acc_d = (mode_q == MODE_DIV)
                ? ((trial >= {1'b0, opr_q}) ? {W'(trial - {1'b0, opr_q}), acc_q[W-2:0], 1'b1}
                                            : {trial[W-1:0], acc_q[W-2:0], 1'b0})
                : {mul_sum, acc_q[W-1:1]};
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            opr_q <= '0;
            mode_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            opr_q <= opr_d;
            mode_q <= mode_d;
            cnt_q <= cnt_d;
        end
    end
    assign prod = acc_q;
    assign quo = acc_q[W-1:0];
    assign rem = acc_q[2*W-1:W];
    assign step_last = (cnt_q == CW'(W - 1));
endmodule

// File: rtl/ula_seq_param.sv
// ula_seq_param: clocked ULA with single-cycle logic/add/sub and iterative mul/div/mod
module ula_seq_param
    import ula_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2:0]     op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           cin,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] result,
    output logic           flag_zero,
    output logic           flag_error,
    output logic           flag_cout
);
    localparam int RW = 2 * W;
    state_t state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    logic cin_q, cin_d;
    logic [RW-1:0] result_q, result_d, res;
    logic zero_q, zero_d, err_q, err_d, cout_q, cout_d, done_q, done_d, busy_q, busy_d;
    logic load, multi, dm_q, dz;
    logic [W:0] sum;
    logic [W-1:0] diff, quo, rem;
    logic [RW-1:0] prod;
    logic step_last;
    ula_iter_muldiv #(.W(W)) u_iter (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .mode((op == OP_DIV || op == OP_MOD) ? MODE_DIV : MODE_MUL),
        .a(a),
        .b(b),
        .prod(prod),
        .quo(quo),
        .rem(rem),
        .step_last(step_last)
    );
    always_comb begin
        sum = {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, cin_q};
        diff = a_q - b_q;
        dm_q = (op_q == OP_DIV || op_q == OP_MOD);
        dz = (b_q == '0);
        // a divide by zero never enters CALC, so it finishes like a single-cycle op
        multi = (op == OP_MUL) || ((op == OP_DIV || op == OP_MOD) && b != '0);
        res = (op_q == OP_ADD) ? RW'(sum) :
              (op_q == OP_SUB) ? RW'(diff) :
              (op_q == OP_AND) ? RW'(a_q & b_q) :
              (op_q == OP_OR)  ? RW'(a_q | b_q) :
              (op_q == OP_XOR) ? RW'(a_q ^ b_q) :
              (op_q == OP_MUL) ? prod :
              dz               ? '0 :
              (op_q == OP_DIV) ? RW'(quo) : RW'(rem);
        state_d = state_q;
        op_d = op_q;
        a_d = a_q;
        b_d = b_q;
        cin_d = cin_q;
        result_d = result_q;
        zero_d = zero_q;
        err_d = err_q;
        cout_d = cout_q;
        done_d = 1'b0;
        busy_d = (state_q == CALC);
        load = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                op_d = op;
                a_d = a;
                b_d = b;
                cin_d = cin;
                load = multi;
                state_d = multi ? CALC : FIM;
            end
            CALC: state_d = step_last ? FIM : CALC;
            FIM: begin
                result_d = res;
                zero_d = (res == '0);
                err_d = ((op_q == OP_SUB) && (a_q < b_q)) || (dm_q && dz);
                cout_d = (op_q == OP_ADD) && sum[W];
                done_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q <= '0;
            a_q <= '0;
            b_q <= '0;
            cin_q <= 1'b0;
            result_q <= '0;
            zero_q <= 1'b0;
            err_q <= 1'b0;
            cout_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            a_q <= a_d;
            b_q <= b_d;
            cin_q <= cin_d;
            result_q <= result_d;
            zero_q <= zero_d;
            err_q <= err_d;
            cout_q <= cout_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign result = result_q;
    assign flag_zero = zero_q;
    assign flag_error = err_q;
    assign flag_cout = cout_q;
endmodule

// File: doc/ula_seq_param.md
Name: ula_seq_param

Overview:
Parametrised, clocked successor to the board-level 4-bit ULA. It latches operands and an opcode on a start strobe and runs single-cycle logic/add/sub operations. Multiply, divide and modulo run iteratively, one bit per clock (shift-add and restoring division). A busy/done handshake and registered flags sit between the switch/key input layer and the BCD/7-segment display path.

Parameters:
W, 4, operand width in bits (W >= 2); result width is 2*W.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 XOR, 110 DIV, 111 MOD
a  input  W  operand A
b  input  W  operand B
cin  input  1  carry-in, used by ADD only
busy  output  1  operation in progress
done  output  1  one-cycle pulse, result/flags valid
result  output  2*W  registered result, zero-extended
flag_zero  output  1  result == 0
flag_error  output  1  SUB borrow (a<b) or DIV/MOD with b==0
flag_cout  output  1  ADD carry-out (sum bit W)

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; busy=0, done=0, result=0, all flags=0, internal regs cleared. Reset mid-operation aborts it; no done is produced.
- FSM states: IDLE, CALC, FIM.
- Operand capture: start=1 in IDLE at edge k latches op, a, b, cin. start in CALC or FIM is ignored; it is neither queued nor able to corrupt latched operands.
- ADD, SUB, AND, OR, XOR: IDLE -> FIM at edge k. Result and flags are registered at edge k+1. done is high during the cycle after edge k+1, so latency L=1. busy stays 0.
- MUL, DIV, MOD: IDLE -> CALC at edge k; busy=1 from edge k+1. Iteration counter runs W steps, then CALC -> FIM. Result registered at edge k+W+1, so L=W+1. busy falls on the same edge that done rises.
- FIM -> IDLE unconditionally after one cycle. Back-to-back start is accepted on the first IDLE cycle, so minimum issue interval is L+1.
- ADD: result = a+b+cin, W+1 bits; flag_cout = bit W.
- SUB: result[W-1:0] = (a-b) mod 2^W, upper bits 0; flag_error = (a<b).
- AND/OR/XOR: bitwise on W bits.
- MUL: unsigned shift-add; result = a*b, full 2W bits.
- DIV: restoring division; result = quotient, zero-extended.
- MOD: restoring division; result = remainder, zero-extended.
- DIV/MOD with b==0: skip CALC, handled like a single-cycle op (L=1). result=0, flag_error=1.
- Flag ownership: flag_cout is meaningful only for ADD, flag_error only for SUB/DIV/MOD; otherwise each is forced 0.
- flag_zero is computed on the registered result. It is 1 for DIV/MOD-by-zero since result=0.
- result and flags hold their values until the next done. No output changes during CALC except busy.

Decomposition:
- Package ula_pkg: opcode localparams (OP_ADD .. OP_MOD), FSM state encoding (IDLE, CALC, FIM), and a function giving counter width $clog2(W)+1.
- One sub-module, ula_iter_muldiv: iterative MUL/restoring DIV datapath.
  - Inputs: clk, rst_n, load, mode, a, b.
  - Outputs: product/quotient/remainder and a step-done indication.
- Top level holds the FSM, the single-cycle ops and the flag registers.

Test Plan (W=4):
1. ADD a=9, b=8, cin=1, start -> done one cycle after capture edge; result=18 (0x12), flag_cout=1, flag_zero=0, busy never high.
2. SUB a=3, b=5 -> result=14 (0x0E), flag_error=1. Then SUB a=5, b=5 -> result=0, flag_zero=1, flag_error=0.
3. MUL a=15, b=15 -> busy for 4 cycles; done at capture+5 edges; result=225 (0xE1). Repeat start held high during busy -> exactly one done.
4. DIV a=13, b=4 -> result=3 after L=5. MOD a=13, b=4 -> result=1. DIV a=7, b=0 -> L=1, result=0, flag_error=1, flag_zero=1.
5. Start MUL a=6, b=7; drop rst_n at capture+2 edges -> busy=0, done=0, result=0 immediately. After release, MUL a=6, b=7 -> result=42.
6. Back-to-back: AND a=0xC, b=0xA then OR a=0xC, b=0xA issued on the first IDLE cycle -> results 8 then 14, each with a single done pulse.
